// File: rtl/de_regfile_cc.sv
// de_regfile_cc: LC-3b decode-stage register file (R0..R7) plus {N,Z,P}
// condition codes, written by the SR stage, with write-first bypass on both
// read ports and on the CC output, and the DE dependency-stall generator.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   v_sr_ld_reg, sr_drid,
//   sr_reg_data                    SR register writeback
//   v_sr_ld_cc, sr_cc_data         SR condition-code writeback
//   de_sr1/de_sr2 -> de_srN_data   combinational read ports (bypassed)
//   de_cc                          current {N,Z,P} (bypassed)
//   de_v, de_sr*_needed, de_br_op  DE instruction source usage
//   v_agex_*/v_mem_*, *_drid       in-flight downstream writers
//   dep_stall                      combinational DE hold request
module de_regfile_cc #(
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_sr_ld_reg,
  input  logic        v_sr_ld_cc,
  input  logic [2:0]  sr_drid,
  input  logic [15:0] sr_reg_data,
  input  logic [2:0]  sr_cc_data,
  input  logic [2:0]  de_sr1,
  input  logic [2:0]  de_sr2,
  output logic [15:0] de_sr1_data,
  output logic [15:0] de_sr2_data,
  output logic [2:0]  de_cc,
  input  logic        de_v,
  input  logic        de_sr1_needed,
  input  logic        de_sr2_needed,
  input  logic        de_br_op,
  input  logic        v_agex_ld_reg,
  input  logic        v_mem_ld_reg,
  input  logic [2:0]  agex_drid,
  input  logic [2:0]  mem_drid,
  input  logic        v_agex_ld_cc,
  input  logic        v_mem_ld_cc,
  output logic        dep_stall
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CC_W   = 3;
  localparam int unsigned N_REGS = 8;

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [CC_W-1:0]   cc_q;
  logic [CC_W-1:0]   cc_d;

  // Next-state: register and CC writes are independent
  always_comb begin
    regs_d = regs_q;
    cc_d   = cc_q;
    if (v_sr_ld_reg) begin
      regs_d[sr_drid] = sr_reg_data;
    end
    if (v_sr_ld_cc) begin
      cc_d = sr_cc_data;
    end
  end

  // State registers; reset discards any coincident write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
      cc_q <= CC_RESET;
    end else begin
      regs_q <= regs_d;
      cc_q   <= cc_d;
    end
  end

  // Read ports with write-first bypass from the SR stage
  always_comb begin
    de_sr1_data = regs_q[de_sr1];
    de_sr2_data = regs_q[de_sr2];
    de_cc       = cc_q;
    if (v_sr_ld_reg && (sr_drid == de_sr1)) begin
      de_sr1_data = sr_reg_data;
    end
    if (v_sr_ld_reg && (sr_drid == de_sr2)) begin
      de_sr2_data = sr_reg_data;
    end
    if (v_sr_ld_cc) begin
      de_cc = sr_cc_data;
    end
  end

  // Dependency stall: only AGEX/MEM writers matter, SR is covered by bypass
  logic hit_sr1;
  logic hit_sr2;
  logic hit_cc;

  always_comb begin
    hit_sr1   = de_sr1_needed &&
                ((v_agex_ld_reg && (agex_drid == de_sr1)) ||
                 (v_mem_ld_reg  && (mem_drid  == de_sr1)));
    hit_sr2   = de_sr2_needed &&
                ((v_agex_ld_reg && (agex_drid == de_sr2)) ||
                 (v_mem_ld_reg  && (mem_drid  == de_sr2)));
    hit_cc    = de_br_op && (v_agex_ld_cc || v_mem_ld_cc);
    dep_stall = de_v && (hit_sr1 || hit_sr2 || hit_cc);
  end

endmodule

// File: doc/de_regfile_cc.md
# de_regfile_cc

Register file and condition-code register for the LC-3b pipeline decode (DE) stage. It is the receiving end of the writeback interface driven by the SR stage. It holds R0–R7 and the {N,Z,P} condition codes, and serves two combinational read ports to DE with same-cycle write bypass. It also generates the DE dependency stall against in-flight register and CC writers in the AGEX and MEM stages.

## Interface

Parameters
- `CC_RESET`, default 3'b010: {N,Z,P} value loaded on reset (Z set).

Ports
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `v_sr_ld_reg`  in  1  SR stage register-write enable.
- `v_sr_ld_cc`  in  1  SR stage CC-write enable.
- `sr_drid`  in  3  destination register index.
- `sr_reg_data`  in  16  writeback value.
- `sr_cc_data`  in  3  {N,Z,P} to load.
- `de_sr1`  in  3  read port 1 index.
- `de_sr2`  in  3  read port 2 index.
- `de_sr1_data`  out  16  read port 1 data.
- `de_sr2_data`  out  16  read port 2 data.
- `de_cc`  out  3  current {N,Z,P}, bypassed.
- `de_v`  in  1  DE latch holds a valid instruction.
- `de_sr1_needed`  in  1  DE instruction reads SR1.
- `de_sr2_needed`  in  1  DE instruction reads SR2.
- `de_br_op`  in  1  DE instruction is BR and reads CC.
- `v_agex_ld_reg`, `v_mem_ld_reg`  in  1 each  downstream stage will write a register.
- `agex_drid`, `mem_drid`  in  3 each  downstream destination indices.
- `v_agex_ld_cc`, `v_mem_ld_cc`  in  1 each  downstream stage will write CC.
- `dep_stall`  out  1  DE must hold and inject a bubble.

## Operation

- State is eight 16-bit registers `R[0..7]` and a 3-bit `cc`. There is no other storage.
- Register write: on a rising edge with `v_sr_ld_reg`=1, `R[sr_drid] <= sr_reg_data`. All other entries hold.
- CC write: on a rising edge with `v_sr_ld_cc`=1, `cc <= sr_cc_data`. The register and CC writes are independent, and both may occur in the same cycle.
- Reads are combinational.
  - `de_srN_data` = `sr_reg_data` when `v_sr_ld_reg` & (`sr_drid`==`de_srN`).
  - Otherwise `de_srN_data` = `R[de_srN]`.
  - Both ports may hit the same index, and both may bypass at once.
- CC bypass: `de_cc` = `sr_cc_data` when `v_sr_ld_cc`=1, otherwise `cc`.
- Because of the bypasses, the SR stage never causes a dependency stall.
- `dep_stall` = `de_v` & (h1 | h2 | hc), where:
  - h1 = `de_sr1_needed` & ((`v_agex_ld_reg` & `agex_drid`==`de_sr1`) | (`v_mem_ld_reg` & `mem_drid`==`de_sr1`))
  - h2 is the same as h1 with `de_sr2_needed` and `de_sr2`.
  - hc = `de_br_op` & (`v_agex_ld_cc` | `v_mem_ld_cc`).
- The block performs no validation of `sr_cc_data`. It stores any 3-bit pattern verbatim.

## Timing

- Reset asserted, asynchronously and at any time including mid-write:
  - All `R[i]` go to 16'h0000 and `cc` goes to `CC_RESET`, immediately.
  - A write coinciding with reset assertion is lost.
  - While `rst`=1, writes are ignored.
  - Outputs during reset: `de_sr1_data`/`de_sr2_data` = 16'h0000 unless a bypass hits. `de_cc` = `CC_RESET` unless `v_sr_ld_cc`=1. `dep_stall` remains purely combinational from its inputs.
- Write latency: the value is visible through the bypass in the write cycle, and through the array from the next cycle on.
- Read latency: 0 cycles, combinational.
- `dep_stall`: 0 cycles, combinational. It has no registered state.
- Write and read of the same index in the same cycle return the new value (write-first).
- Two downstream writers of the same index, AGEX and MEM both matching, produce a single stall. The block treats this as one hazard.

## Test plan

- Reset: pulse `rst` mid-cycle with `v_sr_ld_reg`=1, `sr_drid`=3, data 16'h1234 → R3 reads 16'h0000 after reset; `de_cc`=3'b010.
- Write/read: write R5=16'hBEEF; next cycle `de_sr1`=5, `de_sr2`=5 → both ports return 16'hBEEF; R4 still 16'h0000.
- Bypass: same cycle `v_sr_ld_reg`=1, `sr_drid`=2, data 16'h8001, `de_sr2`=2 → `de_sr2_data`=16'h8001 before the edge. `v_sr_ld_cc`=1, `sr_cc_data`=3'b100 → `de_cc`=3'b100 same cycle and after.
- Independent enables: `v_sr_ld_reg`=0, `v_sr_ld_cc`=1 with `sr_drid`=1, data 16'hFFFF → R1 unchanged, `cc` updates.
- Stall: `de_v`=1, `de_sr1_needed`=1, `de_sr1`=6, `v_mem_ld_reg`=1, `mem_drid`=6 → `dep_stall`=1. Then set `de_v`=0 → 0. Then `de_sr1_needed`=0 → 0. Then `de_br_op`=1, `v_agex_ld_cc`=1, `de_v`=1 → 1.
- Sweep: write R0–R7 with 16'h1111×(i+1) on consecutive cycles; read all pairs → match; R7 = 16'h8888.
